mem_bus_arbiter: RTL

- Shares one single-ported unified memory bus between the instruction-fetch port (IF stage) and the data port (MEM stage) of the 5-stage pipeline.
- Holds one outstanding transaction at a time.
- Data requests have priority, with a bounded-streak rule so fetch cannot starve.
- Returns per-port response pulses and stall levels that the pipeline uses to freeze IF/ID and the upstream stages.

---
 rtl/mem_bus_arbiter_pkg.sv | 23 ++
 rtl/mem_bus_arbiter_if.sv | 49 ++++
 rtl/mem_bus_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared bus command encodings and the arbiter's
// state / grant enumerations. Imported by the interface, the arbiter and
// its testbench.
package mem_bus_arbiter_pkg;

  // Memory bus command encodings (2-bit command field).
  localparam logic [1:0] BUS_NONE  = 2'h0;
  localparam logic [1:0] BUS_LOAD  = 2'h1;
  localparam logic [1:0] BUS_STORE = 2'h2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } arb_grant_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: bundles the fetch port, data port and unified memory
// bus signals of the arbiter.
//   proc2Imem_* / Imem2proc_* / if_stall   : instruction-fetch port
//   proc2Dmem_* / Dmem2proc_* / mem_stall  : data port
//   proc2mem_*  / mem2proc_*               : shared memory bus
// Modports:
//   slave  : the arbiter's view
//   master : the environment's view (pipeline + memory)
interface mem_bus_arbiter_if;

  logic [1:0]  proc2Imem_command;
  logic [31:0] proc2Imem_addr;
  logic [31:0] Imem2proc_data;
  logic        Imem2proc_valid;
  logic        if_stall;

  logic [1:0]  proc2Dmem_command;
  logic [31:0] proc2Dmem_addr;
  logic [31:0] proc2Dmem_data;
  logic [31:0] Dmem2proc_data;
  logic        Dmem2proc_valid;
  logic        mem_stall;

  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [31:0] proc2mem_data;
  logic        mem2proc_ready;
  logic        mem2proc_resp_valid;
  logic [31:0] mem2proc_data;

  modport slave (
    input  proc2Imem_command, proc2Imem_addr,
    output Imem2proc_data, Imem2proc_valid, if_stall,
    input  proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
    output Dmem2proc_data, Dmem2proc_valid, mem_stall,
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    input  mem2proc_ready, mem2proc_resp_valid, mem2proc_data
  );

  modport master (
    output proc2Imem_command, proc2Imem_addr,
    input  Imem2proc_data, Imem2proc_valid, if_stall,
    output proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
    input  Dmem2proc_data, Dmem2proc_valid, mem_stall,
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    output mem2proc_ready, mem2proc_resp_valid, mem2proc_data
  );

endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares a single-ported unified memory bus between the
// instruction-fetch port and the data port. One transaction is outstanding
// at a time. Data requests win, but after MAX_D_STREAK consecutive data
// grants made while a fetch waits, the fetch is forced through.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : mem_bus_arbiter_if.slave (fetch port, data port, memory bus)
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 4  // 1..15
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_bus_arbiter_if.slave      bus
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  arb_state_t  state_q,     state_d;
  arb_grant_t  grant_q,     grant_d;
  logic [3:0]  d_streak_q,  d_streak_d;
  logic [31:0] resp_data_q, resp_data_d;

  logic i_pend;
  logic d_pend;

  // Any non-NONE fetch command counts as a load request.
  assign i_pend = (bus.proc2Imem_command != BUS_NONE);
  assign d_pend = (bus.proc2Dmem_command != BUS_NONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= GRANT_I;
      d_streak_q  <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      d_streak_q  <= d_streak_d;
      resp_data_q <= resp_data_d;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d              = state_q;
    grant_d              = grant_q;
    d_streak_d           = d_streak_q;
    resp_data_d          = resp_data_q;
    bus.proc2mem_command = BUS_NONE;
    bus.proc2mem_addr    = '0;
    bus.proc2mem_data    = '0;
    bus.Imem2proc_valid  = 1'b0;
    bus.Dmem2proc_valid  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (d_pend && (!i_pend || d_streak_q < STREAK_MAX)) begin
          grant_d = GRANT_D;
          state_d = REQ;
          // The streak only grows while a fetch is actually being held off.
          if (!i_pend)
            d_streak_d = '0;
          else if (d_streak_q < STREAK_MAX)
            d_streak_d = d_streak_q + 4'd1;
        end else if (i_pend) begin
          grant_d    = GRANT_I;
          state_d    = REQ;
          d_streak_d = '0;
        end
      end

      REQ: begin
        if (grant_q == GRANT_D) begin
          bus.proc2mem_command = bus.proc2Dmem_command;
          bus.proc2mem_addr    = bus.proc2Dmem_addr;
          bus.proc2mem_data    = bus.proc2Dmem_data;
        end else begin
          bus.proc2mem_command = BUS_LOAD;
          bus.proc2mem_addr    = bus.proc2Imem_addr;
        end
        if (bus.mem2proc_ready)
          state_d = WAIT;
      end

      WAIT: begin
        if (bus.mem2proc_resp_valid) begin
          resp_data_d = bus.mem2proc_data;
          state_d     = RESP;
        end
      end

      RESP: begin
        bus.Imem2proc_valid = (grant_q == GRANT_I);
        bus.Dmem2proc_valid = (grant_q == GRANT_D);
        state_d             = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.Imem2proc_data = resp_data_q;
  assign bus.Dmem2proc_data = resp_data_q;

  assign bus.if_stall  = i_pend & ~bus.Imem2proc_valid;
  assign bus.mem_stall = d_pend & ~bus.Dmem2proc_valid;

endmodule
